// File: rtl/bitrev_frame_buffer.sv
// Ping-pong reorder buffer ahead of the FFT butterflies.
// Frames are written bit-reversed and streamed out in natural order.
module bitrev_frame_buffer #(
  parameter int N      = 16,
  parameter int SIZE   = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_first,
  output logic              out_last,
  output logic [7:0]        frame_cnt
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [SIZE-1:0] LAST = SIZE'(N - 1);

  function automatic logic [SIZE-1:0] bitrev(
    input logic [SIZE-1:0] a
  );
    logic [SIZE-1:0] r;
    for (int j = 0; j < SIZE; j++) begin
      r[j] = a[SIZE-1-j];
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [SIZE-1:0]   wr_idx_q, wr_idx_d;
  logic [1:0]        full_q, full_d;
  logic              rd_bank_q, rd_bank_d;
  logic [SIZE-1:0]   rd_addr_q, rd_addr_d;
  logic              out_valid_q, out_valid_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_re_q, out_re_d;
  logic [DATA_W-1:0] out_im_q, out_im_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic [2*DATA_W-1:0] mem_q [2*N];
  logic [2*DATA_W-1:0] rd_word;
  logic                accept;

  assign in_ready = !full_q[wr_bank_q] && !rst;
  assign accept   = in_valid && in_ready;
  assign rd_word  = mem_q[{rd_bank_q, rd_addr_q}];

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[{wr_bank_q, bitrev(wr_idx_q)}] <= {in_re, in_im};
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    full_d      = full_q;
    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    frame_cnt_d = frame_cnt_q;

    if (accept) begin
      wr_idx_d = wr_idx_q + SIZE'(1);
      if (wr_idx_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d   = READ;
          rd_addr_d = '0;
        end
      end
      READ: begin
        rd_addr_d   = rd_addr_q + SIZE'(1);
        out_valid_d = 1'b1;
        out_first_d = (rd_addr_q == '0);
        out_last_d  = (rd_addr_q == LAST);
        out_re_d    = rd_word[2*DATA_W-1:DATA_W];
        out_im_d    = rd_word[DATA_W-1:0];
        if (rd_addr_q == LAST) begin
          // Writer never targets the bank being drained, so no clash.
          state_d           = IDLE;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          frame_cnt_d       = frame_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      full_q      <= 2'b00;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      full_q      <= full_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_bitrev_frame_buffer.sv
// Scoreboard bench for bitrev_frame_buffer.
// Frames are modelled on input and checked in natural output order.
module tb_bitrev_frame_buffer;
  localparam int N    = 16;
  localparam int SIZE = 4;
  localparam int W    = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic         out_first;
  logic         out_last;
  logic [7:0]   frame_cnt;

  bitrev_frame_buffer #(.N(N), .SIZE(SIZE), .DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
    .out_first(out_first), .out_last(out_last),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         first;
    logic         last;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] fre[N];
  logic [W-1:0] fim[N];
  int           mk;
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           stalls = 0;
  int           first_cyc = 0;
  int           t_acc = 0;
  int           idle_run = 0;
  logic         mon_en = 1'b0;
  logic         chk_gap = 1'b0;
  logic         after_last = 1'b0;
  logic         prev_mid = 1'b0;
  logic [W-1:0] last_re = '0;
  logic [W-1:0] last_im = '0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bitrev(int a);
    int r = 0;
    for (int j = 0; j < SIZE; j++) begin
      if (a[j]) r |= 1 << (SIZE - 1 - j);
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst || !mon_en) begin
      last_re = '0; last_im = '0;
      prev_mid = 1'b0; idle_run = 0;
      after_last = 1'b0;
    end else begin
      if (prev_mid) chk("burst_contig", out_valid, 1'b1);
      if (out_valid) begin
        if (chk_gap && after_last)
          chk("frame_gap", idle_run <= 1, 1'b1);
        idle_run = 0;
        after_last = out_last;
        chk("q_nonempty", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("out_re", out_re, e.re);
          chk("out_im", out_im, e.im);
          chk("out_first", out_first, e.first);
          chk("out_last", out_last, e.last);
        end
        if (out_first) first_cyc = cyc;
        prev_mid = !out_last;
        last_re = out_re;
        last_im = out_im;
      end else begin
        chk("hold_re", out_re, last_re);
        chk("hold_im", out_im, last_im);
        prev_mid = 1'b0;
        if (after_last && q.size() > 0) idle_run++;
      end
    end
  end

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im);
    int n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_re = re;
    in_im = im;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (n >= 100) chk("ready_timeout", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    t_acc = cyc;
    fre[mk] = re;
    fim[mk] = im;
    mk++;
    if (mk == N) begin
      for (int p = 0; p < N; p++) begin
        e.re = fre[bitrev(p)];
        e.im = fim[bitrev(p)];
        e.first = (p == 0);
        e.last = (p == N - 1);
        q.push_back(e);
      end
      mk = 0;
    end
  endtask

  task automatic send_ramp(input logic gapped);
    for (int k = 0; k < N; k++) begin
      send(W'(k), W'(-k));
      if (gapped) @(negedge clk);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 400, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_fcnt", frame_cnt, 8'd0);
    rst = 1'b0;
    mk = 0;
    q.delete();
    #1;
    chk("post_rst_ready", in_ready, 1'b1);
  endtask

  initial begin
    int n;
    mk = 0;
    repeat (2) @(negedge clk);
    chk("init_valid", out_valid, 1'b0);
    chk("init_first", out_first, 1'b0);
    chk("init_last", out_last, 1'b0);
    chk("init_re", out_re, 16'h0);
    chk("init_im", out_im, 16'h0);
    chk("init_fcnt", frame_cnt, 8'd0);
    chk("init_ready", in_ready, 1'b0);
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("ready_after_rst", in_ready, 1'b1);

    send_ramp(1'b0);
    drain();
    chk("latency", first_cyc - t_acc, 2);
    chk("fcnt_single", frame_cnt, 8'd1);

    stalls = 0;
    chk_gap = 1'b1;
    for (int i = 0; i < 4 * N; i++) begin
      send(W'($urandom), W'($urandom));
    end
    drain();
    chk_gap = 1'b0;
    chk("stream_stalls_bounded", stalls <= 4, 1'b1);
    chk("fcnt_stream", frame_cnt, 8'd5);

    send_ramp(1'b1);
    drain();
    chk("fcnt_gapped", frame_cnt, 8'd6);

    stalls = 0;
    for (int i = 0; i < 3 * N; i++) begin
      send(W'(i * 7 + 3), W'(~i));
    end
    drain();
    chk("overflow_backpressure", stalls > 0, 1'b1);
    chk("fcnt_overflow", frame_cnt, 8'd9);

    for (int k = 0; k < 7; k++) send(W'(16'hdead), W'(k));
    @(negedge clk);
    reset_pulse();
    send_ramp(1'b0);
    drain();
    chk("fcnt_after_partial", frame_cnt, 8'd1);

    for (int k = 0; k < N; k++) send(W'(k + 100), W'(k + 200));
    n = 0;
    while (!out_first && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_timeout", n < 100, 1'b1);
    repeat (5) @(negedge clk);
    chk("mid_burst_valid", out_valid, 1'b1);
    reset_pulse();
    chk("abort_fcnt", frame_cnt, 8'd0);
    send_ramp(1'b0);
    drain();
    chk("fcnt_after_abort", frame_cnt, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
